// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit of the input is consumed per cycle; the packed BCD result and the
// overflow flag are published together in a single LOAD cycle and held
// stable until the next conversion completes.
module bin_to_bcd_seq #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]         MAX_BCD = pow10(DIGITS) - 64'd1;
    localparam logic [4*DIGITS-1:0] SAT_BCD = {DIGITS{4'h9}};
    localparam logic [CW-1:0]       LAST    = CW'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IN_WIDTH-1:0]   shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic                  ovf_pending;

    logic [4*DIGITS-1:0]   scratch_next;
    logic [3:0]            digit_adj;
    logic                  carry;
    logic                  ovf_in;

    // Unsigned range check of the incoming value against 10^DIGITS-1.
    always_comb begin
        ovf_in = (64'(value) > MAX_BCD);
    end

    // Add-3 on the pre-shift digits, then shift left by one with the shift
    // register MSB entering the ones digit; carry out of the top digit is dropped.
    always_comb begin
        scratch_next = '0;
        digit_adj    = '0;
        carry        = shreg[IN_WIDTH-1];
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_adj = scratch[4*i +: 4];
            if (digit_adj >= 4'd5) begin
                digit_adj = digit_adj + 4'd3;
            end
            scratch_next[4*i +: 4] = {digit_adj[2:0], carry};
            carry = digit_adj[3];
        end
    end

    // Control FSM with registered busy/done/overflow/bcd outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            scratch     <= '0;
            ovf_pending <= 1'b0;
            bcd         <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= value;
                        scratch     <= '0;
                        cnt         <= '0;
                        ovf_pending <= ovf_in;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= {shreg[IN_WIDTH-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bcd      <= ovf_pending ? SAT_BCD : scratch;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq with hand-computed expected values.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd;

    int checks;
    int errors;

    int first_done;
    int n_done;
    int n_busy;
    bit stable;
    int d1;
    int d2;
    logic [31:0] b1;
    logic [31:0] b2;

    bin_to_bcd_seq #(
        .IN_WIDTH (32),
        .DIGITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start with value v, then watches 41 cycles after the start edge.
    // Index n means "sampled 1ns after edge En" (E0 = start edge).
    task automatic conv(input logic [31:0] v, input int poke_at, input int rst_at,
                        output int fd, output int nd, output int nb, output bit st);
        logic [31:0] b0;
        logic        o0;
        b0 = bcd;
        o0 = overflow;
        @(posedge clk); #1;
        value = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = 32'hDEAD_BEEF;
        fd = -1;
        nd = 0;
        nb = 0;
        st = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (busy) nb++;
            if (done) begin
                nd++;
                if (fd < 0) fd = n;
            end else if (fd < 0 && (bcd !== b0 || overflow !== o0)) begin
                st = 1'b0;
            end
            if (poke_at > 0 && n == poke_at - 1) begin
                start = 1'b1;
                value = 32'd7;
            end
            if (poke_at > 0 && n == poke_at) start = 1'b0;
            if (rst_at > 0 && n == rst_at - 1) rst = 1'b1;
            if (rst_at > 0 && n == rst_at) rst = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        value  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd", bcd, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", overflow, 0);
        rst = 1'b0;

        // value 0: latency and busy length
        conv(32'd0, 0, 0, first_done, n_done, n_busy, stable);
        check("zero_done_edge", first_done, 33);
        check("zero_done_count", n_done, 1);
        check("zero_busy_cycles", n_busy, 33);
        check("zero_bcd", bcd, 32'h0000_0000);
        check("zero_ovf", overflow, 0);

        conv(32'h00BC_614E, 0, 0, first_done, n_done, n_busy, stable);
        check("12345678_bcd", bcd, 32'h1234_5678);
        check("12345678_ovf", overflow, 0);
        check("12345678_done_edge", first_done, 33);

        conv(32'd99999999, 0, 0, first_done, n_done, n_busy, stable);
        check("max_bcd", bcd, 32'h9999_9999);
        check("max_ovf", overflow, 0);
        check("max_prev_stable", stable, 1);

        conv(32'd100000000, 0, 0, first_done, n_done, n_busy, stable);
        check("max1_bcd", bcd, 32'h9999_9999);
        check("max1_ovf", overflow, 1);

        conv(32'hFFFF_FFFF, 0, 0, first_done, n_done, n_busy, stable);
        check("allones_bcd", bcd, 32'h9999_9999);
        check("allones_ovf", overflow, 1);

        conv(32'd10, 0, 0, first_done, n_done, n_busy, stable);
        check("ten_bcd", bcd, 32'h0000_0010);
        check("ten_ovf_cleared", overflow, 0);
        check("ten_prev_stable", stable, 1);

        // second start during conversion is ignored
        conv(32'd42, 10, 0, first_done, n_done, n_busy, stable);
        check("ignore_done_count", n_done, 1);
        check("ignore_bcd", bcd, 32'h0000_0042);

        // reset in the middle of a conversion
        conv(32'd12345678, 0, 15, first_done, n_done, n_busy, stable);
        check("abort_no_done", n_done, 0);
        check("abort_bcd", bcd, 0);
        check("abort_busy", busy, 0);
        check("abort_ovf", overflow, 0);

        conv(32'd9, 0, 0, first_done, n_done, n_busy, stable);
        check("after_abort_bcd", bcd, 32'h0000_0009);

        // back-to-back: new start held during the done cycle
        @(posedge clk); #1;
        value = 32'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = 32'd0;
        d1 = -1;
        d2 = -1;
        b1 = '0;
        b2 = '0;
        for (int n = 0; n <= 75; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (d1 >= 0 && n == d1 + 1) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    b1 = bcd;
                    start = 1'b1;
                    value = 32'd250;
                end else if (d2 < 0) begin
                    d2 = n;
                    b2 = bcd;
                end
            end
        end
        check("b2b_first_edge", d1, 33);
        check("b2b_second_edge", d2, 67);
        check("b2b_first_bcd", b1, 32'h0000_0001);
        check("b2b_second_bcd", b2, 32'h0000_0250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3) that feeds the 7-segment output manager.
- Converts a 32-bit unsigned value into DIGITS packed BCD digits over IN_WIDTH cycles.
- Holds each result stable between conversions so the downstream per-digit decode never sees a half-converted value.

Parameters:
- IN_WIDTH, 32: width of the binary input; also the number of shift iterations.
- DIGITS, 8: number of BCD digits produced; maximum representable value is 10^DIGITS-1 (99,999,999).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- value  input  IN_WIDTH  unsigned binary to convert; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress (SHIFT or LOAD state).
- done  output  1  one-cycle pulse: bcd/overflow just updated.
- overflow  output  1  last accepted value exceeded 10^DIGITS-1.
- bcd  output  4*DIGITS  packed result; bcd[3:0] is ones, bcd[4*DIGITS-1:4*DIGITS-4] is the most significant digit.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=IDLE, iteration counter=0;
  - bcd=0, done=0, busy=0, overflow=0;
  - internal shift/scratch registers cleared.
- Reset overrides everything. Reset mid-conversion aborts it: no done pulse, and bcd is cleared to 0.
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - On start=1 at edge E0: capture value into the shift register, clear the BCD scratch, clear the counter, latch ovf_pending = (value > 10^DIGITS-1) as an unsigned compare, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one iteration per edge E1..E(IN_WIDTH):
  - Every scratch digit >= 5 gets +3, evaluated on the pre-shift digits.
  - Then {scratch, shreg} shifts left by 1; the MSB of shreg enters scratch bit 0.
  - Counter increments each iteration.
  - On the iteration where counter == IN_WIDTH-1, go to LOAD.
- LOAD at edge E(IN_WIDTH+1):
  - bcd <= ovf_pending ? all digits 9 (0x99999999 for defaults) : scratch.
  - overflow <= ovf_pending; done <= 1; go to IDLE.
- Carry out of the top scratch digit is discarded. This only occurs when ovf_pending=1, whose result is saturated anyway.
- done is registered:
  - high exactly during the cycle after E(IN_WIDTH+1), i.e. 33 edges after the start edge for defaults;
  - cleared on the following edge.
- busy is registered: high in cycles after E0 through E(IN_WIDTH+1), low from the cycle in which done is high.
- start while busy=1 is ignored: no queueing, and value is not re-sampled.
- start high in the same cycle done is high is accepted (state is IDLE). Back-to-back throughput is one conversion per IN_WIDTH+2 cycles (34 for defaults).
- bcd and overflow change only at LOAD or reset; they are stable at all other times.
- value may change freely after the capture edge without affecting the result.

Test Plan:
- Reset, then start with value=0 → done pulse 33 edges after the start edge; bcd=0x00000000, overflow=0; busy high for exactly 33 cycles.
- value=12345678 (0x00BC614E) → bcd=0x12345678, overflow=0; bcd unchanged until the next done.
- value=99999999 → bcd=0x99999999, overflow=0. Then value=100000000 → bcd=0x99999999, overflow=1. Then value=0xFFFFFFFF → bcd=0x99999999, overflow=1.
- Start with value=42, pulse start again with value=7 at edge E10 → the second start is ignored; exactly one done; bcd=0x00000042.
- Start with value=12345678, assert rst at edge E15 → no done pulse; bcd=0, busy=0. A later start with value=9 → bcd=0x00000009.
- Back-to-back: start value=1, then start value=250 held high in the done cycle → second done 34 cycles after the first; bcd sequence 0x00000001 then 0x00000250.
